nx_msg_packer: RTL

- Packs the 31-bit Nexus message stream produced by the Nexus core's outbound ports (control or mesh) into AXI4-stream beats for the host DMA.
- Sits directly downstream of the core and feeds the host-facing outbound AXI4-stream.
- Each beat carries SLOTS = AXI4_DATA_WIDTH/32 slots. A partial beat is flushed after an idle timeout, and tlast delimits packets.

---
 rtl/nx_msg_packer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nx_msg_packer.sv
// nx_msg_packer: packs 31-bit Nexus messages into AXI4-stream beats of
// SLOTS = AXI4_DATA_WIDTH/32 slots. Each slot is {valid, message}. A partial
// beat is flushed after FLUSH_TIMEOUT idle cycles, and tlast closes a packet
// on a flush or on the PKT_BEATS-th beat.
// Optional statistics outputs are enabled with `define NX_MSG_PACKER_STATS_EN.
module nx_msg_packer #(
  parameter int AXI4_DATA_WIDTH = 128,
  parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH/8,
  parameter int FLUSH_TIMEOUT   = 16,
  parameter int PKT_BEATS       = 8
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [30:0]                ib_nx_data_i,
  input  logic                       ib_nx_valid_i,
  output logic                       ib_nx_ready_o,
  output logic [AXI4_DATA_WIDTH-1:0] ob_axi4s_tdata_o,
  output logic [AXI4_STRB_WIDTH-1:0] ob_axi4s_tkeep_o,
  output logic                       ob_axi4s_tlast_o,
  output logic                       ob_axi4s_tvalid_o,
  input  logic                       ob_axi4s_tready_i,
  output logic                       idle_o
`ifdef NX_MSG_PACKER_STATS_EN
  ,
  output logic [31:0]                stat_msgs_o,
  output logic [31:0]                stat_beats_o,
  output logic [15:0]                stat_flushes_o
`endif
);

  localparam int SLOTS = AXI4_DATA_WIDTH/32;
  localparam int CW    = $clog2(SLOTS + 1);
  localparam int BW    = $clog2(PKT_BEATS + 1);

  logic [AXI4_DATA_WIDTH-1:0] acc_data;
  logic [CW-1:0]              acc_count;
  logic                       acc_flush;
  logic [7:0]                 idle_cnt;
  logic [BW-1:0]              beat_cnt;

  logic        acc_full;
  logic        acc_send;
  logic        move;
  logic        accept;
  logic        idle_cycle;
  logic        flush_set;
  logic        last_next;
  logic [31:0] slot_word;

  assign acc_full   = (acc_count == CW'(SLOTS));
  assign acc_send   = acc_full | acc_flush;
  assign move       = acc_send & (~ob_axi4s_tvalid_o | ob_axi4s_tready_i);
  assign ib_nx_ready_o = ~acc_send | move;
  assign accept     = ib_nx_valid_i & ib_nx_ready_o;
  assign slot_word  = {1'b1, ib_nx_data_i};
  // A partially filled accumulator with nothing arriving is an idle cycle.
  assign idle_cycle = (acc_count != '0) & ~acc_full & ~acc_flush & ~accept & ~move;
  // An acceptance in the same cycle suppresses the timeout (idle_cycle is low).
  assign flush_set  = idle_cycle & (idle_cnt == 8'(FLUSH_TIMEOUT - 1));
  assign last_next  = acc_flush | (beat_cnt == BW'(PKT_BEATS - 1));
  assign ob_axi4s_tkeep_o = '1;
  assign idle_o     = (acc_count == '0) & ~ob_axi4s_tvalid_o;

  // Accumulator: fill slots in order, clear on move, arm flush on idle timeout.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_data  <= '0;
      acc_count <= '0;
      acc_flush <= 1'b0;
      idle_cnt  <= '0;
    end else if (move) begin
      acc_flush <= 1'b0;
      idle_cnt  <= '0;
      if (accept) begin
        acc_data  <= AXI4_DATA_WIDTH'(slot_word);
        acc_count <= CW'(1);
      end else begin
        acc_data  <= '0;
        acc_count <= '0;
      end
    end else if (accept) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (acc_count == CW'(k)) acc_data[32*k +: 32] <= slot_word;
      end
      acc_count <= acc_count + CW'(1);
      idle_cnt  <= '0;
    end else if (flush_set) begin
      acc_flush <= 1'b1;
      idle_cnt  <= 8'(FLUSH_TIMEOUT);
    end else if (idle_cycle) begin
      idle_cnt  <= idle_cnt + 8'd1;
    end
  end

  // Output register and packet position. beat_cnt tracks beats committed to
  // the output register; every committed beat is emitted later in order, so
  // this equals the emitted-beat position of the beat being loaded.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ob_axi4s_tdata_o  <= '0;
      ob_axi4s_tlast_o  <= 1'b0;
      ob_axi4s_tvalid_o <= 1'b0;
      beat_cnt          <= '0;
    end else if (move) begin
      ob_axi4s_tdata_o  <= acc_data;
      ob_axi4s_tlast_o  <= last_next;
      ob_axi4s_tvalid_o <= 1'b1;
      beat_cnt          <= last_next ? '0 : beat_cnt + BW'(1);
    end else if (ob_axi4s_tready_i) begin
      ob_axi4s_tvalid_o <= 1'b0;
    end
  end

`ifdef NX_MSG_PACKER_STATS_EN
  // Wrapping event counters for accepted messages, emitted beats and flushes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stat_msgs_o    <= '0;
      stat_beats_o   <= '0;
      stat_flushes_o <= '0;
    end else begin
      if (accept) stat_msgs_o <= stat_msgs_o + 32'd1;
      if (ob_axi4s_tvalid_o && ob_axi4s_tready_i) stat_beats_o <= stat_beats_o + 32'd1;
      if (flush_set) stat_flushes_o <= stat_flushes_o + 16'd1;
    end
  end
`else
  // Statistics disabled: no counters are built.
`endif

endmodule
